// File: rtl/pipelined_segment_adder.sv
// rtl/pipelined_segment_adder.sv - pipelined segmented WIDTH-bit add/subtract on a valid/ready stream
// Optional feature macro: PSA_OVERFLOW_FLAG_EN (adds out_ovf, signed overflow flag).
// Layer 0 captures the operands (b already inverted for subtract). Layer k+1 holds
// the result of carry segment k. Upper operand bits ride along in skew registers
// and finished low sum bits are forwarded, so each layer adds only SEG bits.
module pipelined_segment_adder #(
  parameter int WIDTH  = 128,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef PSA_OVERFLOW_FLAG_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int SEG = WIDTH / STAGES;

  // Per-layer state: valid, carry into the next segment, accumulated low sum bits.
  logic             vld_q [STAGES+1];
  logic             cy_q  [STAGES+1];
  logic [WIDTH-1:0] sum_q [STAGES+1];
  // Operand skew registers; the last adder layer consumes them, so no copy past it.
  logic [WIDTH-1:0] a_q   [STAGES];
  logic [WIDTH-1:0] b_q   [STAGES];
  // Segment k result including its carry-out in the top bit.
  logic [SEG:0]     seg_d [STAGES];
  logic             advance;

  // The whole pipe moves together; it only holds when the output is full and blocked.
  assign advance   = !vld_q[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_q[STAGES];
  assign out_sum   = sum_q[STAGES];
  assign out_cout  = cy_q[STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    assign seg_d[k] = {1'b0, a_q[k][k*SEG +: SEG]}
                    + {1'b0, b_q[k][k*SEG +: SEG]}
                    + {{SEG{1'b0}}, cy_q[k]};
  end

  // Operand capture and segment-by-segment carry propagation, held on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        vld_q[k] <= 1'b0;
        cy_q[k]  <= 1'b0;
        sum_q[k] <= '0;
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
    end else if (advance) begin
      vld_q[0] <= in_valid;
      // Subtract is a + ~b + 1, so the carry-in is forced and in_cin ignored.
      cy_q[0]  <= in_sub | in_cin;
      sum_q[0] <= '0;
      a_q[0]   <= in_a;
      b_q[0]   <= in_sub ? ~in_b : in_b;
      for (int k = 0; k < STAGES; k++) begin
        vld_q[k+1]                 <= vld_q[k];
        cy_q[k+1]                  <= seg_d[k][SEG];
        sum_q[k+1]                 <= sum_q[k];
        sum_q[k+1][k*SEG +: SEG]   <= seg_d[k][SEG-1:0];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_q[k+1] <= a_q[k];
        b_q[k+1] <= b_q[k];
      end
    end
  end

`ifdef PSA_OVERFLOW_FLAG_EN
  logic ovf_q;

  // Carry into the MSB is a^b^sum at that bit; overflow is it XOR the carry out.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (advance) begin
      ovf_q <= a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1]
             ^ seg_d[STAGES-1][SEG-1] ^ seg_d[STAGES-1][SEG];
    end
  end

  assign out_ovf = ovf_q;
`endif

endmodule
